// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//   Burst sequencer that sits directly in front of the 128x8 lab memory. It
//   takes one command at a time. A write burst drains a valid/ready byte
//   stream into consecutive memory addresses. A read burst fills a
//   valid/ready byte stream from consecutive memory addresses. Addresses
//   wrap modulo 2^ADDR_W.
//
//   The memory samples ren/wen/addr/din on the negedge. Every mem_* output is
//   therefore registered on the posedge, which makes each strobe exactly one
//   full clock wide. Read data is valid by the posedge that closes the issue
//   cycle.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_*              command handshake; cmd_op 0=write, 1=read;
//                      cmd_len = bytes-1
//   wr_data/valid/rdy  write byte stream (accepted only in WRITE)
//   rd_data/valid/rdy  read byte stream (held until popped)
//   busy, done         busy = not idle; done = one-cycle completion pulse
//   mem_*              memory strobe, address and data interface

module mem_burst_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign wr_ready  = (state == S_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            // Strobes are single-cycle by default. They are re-armed below
            // only on the edge that enters the cycle needing them.
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr <= cmd_addr;
                        cnt  <= cmd_len;
                        if (cmd_op) begin
                            // Issue the first read on the accept edge so the
                            // RD_ISSUE cycle already carries the strobe.
                            state    <= S_RD_ISSUE;
                            mem_ren  <= 1'b1;
                            mem_addr <= cmd_addr;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // wr_ready is high in this state, so wr_valid alone
                    // completes the handshake. mem_din holds between bytes.
                    if (wr_valid) begin
                        mem_wen  <= 1'b1;
                        mem_addr <= addr;
                        mem_din  <= wr_data;
                        addr     <= addr + ONE;
                        if (cnt == '0) state <= S_DONE;
                        else           cnt   <= cnt - ONE;
                    end
                end
                S_RD_ISSUE: begin
                    // The memory updated dout on the negedge inside this cycle.
                    rd_data  <= mem_dout;
                    rd_valid <= 1'b1;
                    addr     <= addr + ONE;
                    state    <= S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    // rd_valid is always set here, so rd_ready is the pop.
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            cnt      <= cnt - ONE;
                            state    <= S_RD_ISSUE;
                            mem_ren  <= 1'b1;
                            mem_addr <= addr;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [6:0] cmd_len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       mem_ren;
    logic       mem_wen;
    logic [6:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = '0;

    mem_burst_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Lab memory model: samples on the negedge, never reset.
    logic [7:0] mem [128] = '{default: 8'h00};
    always @(negedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_addr];
    end

    // Event counters sampled mid-cycle.
    int ren_cnt = 0, done_cnt = 0, ovl_cnt = 0;
    always @(negedge clk) begin
        if (mem_ren) ren_cnt <= ren_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_ren && mem_wen) ovl_cnt <= ovl_cnt + 1;
    end

    int checks = 0, errors = 0;
    logic [7:0] wbuf [128];
    logic [7:0] ebuf [128];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write burst with wr_valid held high; data from wbuf.
    task automatic do_write(input logic [6:0] a, input logic [6:0] l);
        logic [6:0] ea;
        chk("wr_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
        chk("wr_busy", busy, 1);
        chk("wr_ready", wr_ready, 1);
        for (int i = 0; i <= int'(l); i++) begin
            wr_valid = 1'b1; wr_data = wbuf[i];
            step();
            ea = a + 7'(i);
            chk("wr_mem_wen", mem_wen, 1);
            chk("wr_mem_addr", mem_addr, ea);
            chk("wr_mem_din", mem_din, wbuf[i]);
        end
        wr_valid = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_ready_done", wr_ready, 0);
        step();
        chk("wr_done_clr", done, 0);
        chk("wr_idle_ready", cmd_ready, 1);
        chk("wr_wen_clr", mem_wen, 0);
    endtask

    // Read burst with rd_ready held high; expected data from ebuf.
    task automatic do_read(input logic [6:0] a, input logic [6:0] l);
        logic [6:0] ea;
        chk("rd_cmd_ready", cmd_ready, 1);
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 7'(i);
            chk("rd_mem_ren", mem_ren, 1);
            chk("rd_mem_addr", mem_addr, ea);
            chk("rd_valid_lo", rd_valid, 0);
            step();
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, ebuf[i]);
            chk("rd_ren_lo", mem_ren, 0);
            step();
        end
        chk("rd_done", done, 1);
        chk("rd_valid_end", rd_valid, 0);
        chk("rd_data_kept", rd_data, ebuf[l]);
        step();
        chk("rd_idle_ready", cmd_ready, 1);
    endtask

    typedef struct packed {
        logic            op;
        logic [6:0]      addr;
        logic [6:0]      len;
        logic [3:0][7:0] d;     // d[0] is the first byte
    } vec_t;

    vec_t tbl [7];

    initial begin
        int d0, r0, hs;
        int pat [7];
        logic [7:0] last;

        tbl[0] = '{1'b0, 7'h10, 7'd3, {8'hA4, 8'hA3, 8'hA2, 8'hA1}};
        tbl[1] = '{1'b1, 7'h10, 7'd3, {8'hA4, 8'hA3, 8'hA2, 8'hA1}};
        tbl[2] = '{1'b0, 7'h7E, 7'd2, {8'h00, 8'h33, 8'h22, 8'h11}};
        tbl[3] = '{1'b1, 7'h7E, 7'd2, {8'h00, 8'h33, 8'h22, 8'h11}};
        tbl[4] = '{1'b1, 7'h7F, 7'd1, {8'h00, 8'h00, 8'h33, 8'h22}};
        tbl[5] = '{1'b0, 7'h20, 7'd0, {8'h00, 8'h00, 8'h00, 8'h5C}};
        tbl[6] = '{1'b1, 7'h20, 7'd0, {8'h00, 8'h00, 8'h00, 8'h5C}};

        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        rst_n = 1'b1;
        step();

        // Table-driven bursts
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k <= int'(tbl[j].len); k++) begin
                wbuf[k] = tbl[j].d[k];
                ebuf[k] = tbl[j].d[k];
            end
            if (tbl[j].op) do_read(tbl[j].addr, tbl[j].len);
            else           do_write(tbl[j].addr, tbl[j].len);
        end

        // Read stall: len=1 at 0x10, rd_ready low for 5 cycles
        r0 = ren_cnt;
        rd_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 7'h10; cmd_len = 7'd1;
        step();
        cmd_valid = 1'b0;
        chk("st_ren0", mem_ren, 1);
        step();
        chk("st_valid0", rd_valid, 1);
        chk("st_data0", rd_data, 8'hA1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("st_hold_valid", rd_valid, 1);
            chk("st_hold_data", rd_data, 8'hA1);
            chk("st_hold_ren", mem_ren, 0);
        end
        rd_ready = 1'b1;
        step();
        chk("st_ren1", mem_ren, 1);
        chk("st_addr1", mem_addr, 7'h11);
        chk("st_popped", rd_valid, 0);
        chk("st_data_kept", rd_data, 8'hA1);
        step();
        chk("st_data1", rd_data, 8'hA2);
        step();
        chk("st_done", done, 1);
        step();
        chk("st_ren_total", ren_cnt - r0, 2);

        // Write with gapped wr_valid and a stray cmd_valid mid-burst
        pat = '{1, 0, 0, 1, 1, 0, 1};
        hs = 0;
        last = 8'h00;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 7'h40; cmd_len = 7'd3;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            wr_valid = (pat[c] != 0);
            wr_data = 8'hB0 + 8'(c);
            cmd_valid = (c == 2);
            cmd_op = 1'b1;
            chk("tg_cmd_ready", cmd_ready, 0);
            step();
            chk("tg_mem_wen", mem_wen, pat[c] != 0);
            if (pat[c] != 0) begin
                chk("tg_mem_addr", mem_addr, 7'h40 + 7'(hs));
                chk("tg_mem_din", mem_din, 8'hB0 + 8'(c));
                last = 8'hB0 + 8'(c);
                ebuf[hs] = last;
                hs++;
            end else if (hs > 0) begin
                chk("tg_din_hold", mem_din, last);
            end
        end
        wr_valid = 1'b0;
        cmd_valid = 1'b0;
        chk("tg_done", done, 1);
        step();
        chk("tg_idle", cmd_ready, 1);
        step();
        chk("tg_no_queued", busy, 0);
        do_read(7'h40, 7'd3);

        // Asynchronous reset after 2 of 5 read bytes
        ebuf[0] = 8'hA1; ebuf[1] = 8'hA2;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 7'h10; cmd_len = 7'd4;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ar_data", rd_data, ebuf[i]);
            step();
        end
        chk("ar_ren_pre", mem_ren, 1);
        chk("ar_busy_pre", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ren", mem_ren, 0);
        chk("ar_rd_valid", rd_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rd_data", rd_data, 0);
        chk("ar_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("ar_post_ready", cmd_ready, 1);
        chk("ar_post_busy", busy, 0);
        wbuf[0] = 8'hC2; wbuf[1] = 8'hC3;
        do_write(7'h12, 7'd1);
        ebuf[0] = 8'hA1; ebuf[1] = 8'hA2; ebuf[2] = 8'hC2; ebuf[3] = 8'hC3;
        do_read(7'h10, 7'd3);

        // Full 128-byte burst across the whole address space
        for (int i = 0; i < 128; i++) begin
            wbuf[i] = 8'(i) ^ 8'h5A;
            ebuf[i] = 8'(i) ^ 8'h5A;
        end
        d0 = done_cnt;
        do_write(7'h00, 7'h7F);
        chk("fb_wr_done_cnt", done_cnt - d0, 1);
        d0 = done_cnt;
        do_read(7'h00, 7'h7F);
        chk("fb_rd_done_cnt", done_cnt - d0, 1);

        chk("ren_wen_overlap", ovl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Burst sequencer directly upstream of the 128x8 lab memory; the only master driving its ren/wen/addr/din and consuming its dout.
- Accepts one command at a time: write burst from a valid/ready byte stream, or read burst to a valid/ready byte stream.
- Generates wrap-around addresses and handles the memory's negedge timing; the memory array is never reset.

Parameters:
- ADDR_W, 7, memory address width; depth is 2^ADDR_W.
- DATA_W, 8, data byte width.

Ports:
- clk  in  1  single clock; all logic here is posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = write burst, 1 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst length minus 1 (1..128 bytes).
- wr_data  in  DATA_W  write stream byte.
- wr_valid  in  1  write byte offered.
- wr_ready  out  1  controller accepts a write byte.
- rd_data  out  DATA_W  read stream byte.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  downstream accepts rd_data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- mem_ren  out  1  to memory ren.
- mem_wen  out  1  to memory wen.
- mem_addr  out  ADDR_W  to memory addr.
- mem_din  out  DATA_W  to memory din.
- mem_dout  in  DATA_W  from memory dout.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except cmd_ready=1. Address, count and rd_data registers are cleared. mem_ren/mem_wen drop immediately, mid-burst included; the remainder of the burst is discarded.
- All mem_* outputs are registered on posedge. The memory samples them on the following negedge, so each mem_ren/mem_wen pulse is exactly one full clk cycle wide.
- mem_ren and mem_wen are never high in the same cycle.
- States: IDLE, WRITE, RD_ISSUE, RD_HOLD, DONE.
- IDLE:
  - On cmd_valid && cmd_ready, latch addr and cnt=cmd_len.
  - Go to WRITE if cmd_op=0, otherwise RD_ISSUE.
  - No other inputs are sampled in IDLE.
- WRITE:
  - wr_ready=1.
  - On each wr_valid && wr_ready edge, register mem_wen=1, mem_addr=addr, mem_din=wr_data for the next cycle. addr increments mod 2^ADDR_W.
  - If cnt==0, go to DONE; otherwise decrement cnt.
  - Cycles without a handshake drive mem_wen=0 next cycle. mem_din holds its last value.
- RD_ISSUE:
  - mem_ren=1 and mem_addr=addr for exactly one cycle.
  - At the closing edge, rd_data<=mem_dout (memory updated it on the intervening negedge) and rd_valid<=1.
  - addr increments mod depth; go to RD_HOLD.
- RD_HOLD:
  - mem_ren=0. rd_data and rd_valid stay stable until rd_ready.
  - On rd_valid && rd_ready: rd_valid<=0. If cnt==0, go to DONE; otherwise decrement cnt and go to RD_ISSUE.
  - Minimum throughput is 2 cycles per byte.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- Latency:
  - Command accept to first mem_wen: 1 cycle after the first wr handshake.
  - Command accept to first rd_valid: 2 edges.
- Wrap: address 2^ADDR_W-1 is followed by 0. A full 128-byte burst touches every address once.
- cmd_valid while busy is ignored (cmd_ready=0) and is not queued.
- rd_data keeps its last value after a pop. A reset returns it to 0.

Test Plan:
- Write cmd addr=0x10, len=3, bytes A1,A2,A3,A4 with wr_valid held high -> mem_wen high 4 consecutive cycles at addrs 0x10..0x13; done pulse 1 cycle after last handshake. Then read same range with rd_ready=1 -> rd_data A1,A2,A3,A4, one byte per 2 cycles; mem_ren pulses never overlap mem_wen.
- Write addr=0x7E, len=2, bytes 11,22,33 -> writes at 0x7E,0x7F,0x00. Read-back returns 11,22,33.
- Read len=1 with rd_ready low for 5 cycles after first rd_valid -> rd_data stable, no further mem_ren until pop; exactly 2 mem_ren pulses total.
- Write len=3 with wr_valid toggling 1,0,0,1,1,0,1 -> mem_wen only in cycles after handshakes; cmd_valid pulsed mid-burst leaves cmd_ready=0 and causes no new burst.
- Assert rst_n=0 after 2 of 5 read bytes -> mem_ren, rd_valid, busy go 0 asynchronously; cmd_ready=1 after release. A new write to the same addresses succeeds and earlier memory contents persist.
- Full burst addr=0x00, len=0x7F, data=addr^0x5A -> 128 writes, read-back matches every byte; single done pulse per burst.
